// File: rtl/noc_pkg.sv
// Shared definitions for the flit traffic generator.
//   CTRL_W / DATA_W : flit control and data widths seen by the router
//   VALID_BIT       : position of the flit valid flag inside the control word
//   ch_state_e      : per-channel sequencer state
//   fold32          : XOR of all 32-bit slices of a data word
//   crc32_step      : one CRC-32 update (poly 0x04C11DB7, MSB first) over a 32-bit word
package noc_pkg;

    localparam int CTRL_W    = 22;
    localparam int DATA_W    = 128;
    localparam int VALID_BIT = CTRL_W - 1;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_WAIT  = 2'd1,
        CH_SEND  = 2'd2,
        CH_DRAIN = 2'd3
    } ch_state_e;

    function automatic logic [31:0] fold32(input logic [DATA_W-1:0] d);
        logic [31:0] acc;
        acc = '0;
        for (int s = 0; s < DATA_W / 32; s++) begin
            acc = acc ^ d[s*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] c;
        c = crc;
        for (int b = 31; b >= 0; b--) begin
            if (c[31] ^ d[b]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ftg_channel.sv
// One traffic-generator channel: script RAM, WAIT/SEND/DRAIN sequencer and the
// receive-side counter/signature for the matching router output port.
// Build option: SIG_CRC_EN selects a CRC-32 signature instead of rotate-XOR.
// Ports:
//   wr_*              script write (already gated by the top)
//   run_len           entries to replay; sampled on run_start and while sending
//   run_start/stop    launch the script / return to IDLE after timeout
//   inj_ready         router accepted the flit currently driven
//   gen_co/gen_do     registered flit towards the router input
//   drained           channel has finished its script
//   mon_en/mon_valid/mon_di  returned flit observation
//   rx_count/rx_sig   saturating flit count and data signature
module ftg_channel
    import noc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DLY_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DLY_W-1:0]         wr_dly,
    input  logic [CTRL_W-1:0]        wr_ctrl,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH):0]   run_len,
    input  logic                     run_start,
    input  logic                     run_stop,
    input  logic                     inj_ready,
    output logic [CTRL_W-1:0]        gen_co,
    output logic [DATA_W-1:0]        gen_do,
    output logic                     drained,
    input  logic                     mon_en,
    input  logic                     mon_valid,
    input  logic [DATA_W-1:0]        mon_di,
    output logic [15:0]              rx_count,
    output logic [31:0]              rx_sig
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DLY_W + CTRL_W + DATA_W;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     rd_q;
    logic [AW-1:0]     rd_addr;
    logic [DLY_W-1:0]  rd_dly;
    logic [CTRL_W-1:0] rd_ctrl;
    logic [DATA_W-1:0] rd_data;

    ch_state_e         state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d, wait_cnt;
    logic              first_q, first_d;
    logic [CTRL_W-1:0] co_q, co_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic [AW:0]       len_m1;
    logic              is_last;

    assign {rd_dly, rd_ctrl, rd_data} = rd_q;
    assign len_m1  = run_len - (AW+1)'(1);
    // The pointer can never run past the last RAM entry, whatever run_len says.
    assign is_last = ({1'b0, ptr_q} == len_m1) || (ptr_q == AW'(DEPTH - 1));

    // Read-before-write: a write on the start edge is not seen by entry 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {wr_dly, wr_ctrl, wr_data};
        end
        rd_q <= mem_q[rd_addr];
    end

    // On the first WAIT cycle the delay comes straight from the RAM read.
    assign wait_cnt = first_q ? rd_dly : cnt_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        co_d    = co_q;
        do_d    = do_q;
        case (state_q)
            CH_IDLE: begin
                if (run_start) begin
                    ptr_d = '0;
                    if (run_len == '0) begin
                        state_d = CH_DRAIN;
                    end else begin
                        state_d = CH_WAIT;
                        first_d = 1'b1;
                    end
                end
            end
            CH_WAIT: begin
                first_d = 1'b0;
                if (wait_cnt == '0) begin
                    state_d = CH_SEND;
                    co_d    = rd_ctrl;
                    do_d    = rd_data;
                end else begin
                    cnt_d = wait_cnt - DLY_W'(1);
                end
            end
            CH_SEND: begin
                if (inj_ready) begin
                    if (is_last) begin
                        state_d = CH_DRAIN;
                        co_d    = '0;
                        do_d    = '0;
                    end else begin
                        // rd_q already holds the next entry (prefetched while sending).
                        ptr_d = ptr_q + AW'(1);
                        if (rd_dly == '0) begin
                            co_d = rd_ctrl;
                            do_d = rd_data;
                        end else begin
                            state_d = CH_WAIT;
                            cnt_d   = rd_dly - DLY_W'(1);
                            co_d    = '0;
                            do_d    = '0;
                        end
                    end
                end
            end
            CH_DRAIN: begin
                co_d = '0;
                do_d = '0;
            end
            default: state_d = CH_IDLE;
        endcase
        if (run_stop) begin
            state_d = CH_IDLE;
            co_d    = '0;
            do_d    = '0;
        end
        // While sending, fetch one entry ahead so a zero-delay flit follows back to back.
        rd_addr = (state_d == CH_SEND) ? ptr_d + AW'(1) : ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            co_q    <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            co_q    <= co_d;
            do_q    <= do_d;
        end
    end

    assign gen_co  = co_q;
    assign gen_do  = do_q;
    assign drained = (state_q == CH_DRAIN);

    logic [15:0] rxc_q;
    logic [31:0] sig_q, sig_d;
`ifdef SIG_CRC_EN
    localparam logic [31:0] SIG_INIT = CRC32_INIT;
    assign sig_d = crc32_step(sig_q, fold32(mon_di));
`else
    localparam logic [31:0] SIG_INIT = 32'h0;
    assign sig_d = {sig_q[30:0], sig_q[31]} ^ fold32(mon_di);
`endif

    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            rxc_q <= '0;
            sig_q <= SIG_INIT;
        end else if (mon_en && mon_valid) begin
            if (rxc_q != 16'hFFFF) begin
                rxc_q <= rxc_q + 16'd1;
            end
            sig_q <= sig_d;
        end
    end

    assign rx_count = rxc_q;
    assign rx_sig   = sig_q;

endmodule

// File: rtl/flit_traffic_gen.sv
// Scripted flit injector and return monitor for a bufferless router.
// Build option: SIG_CRC_EN (CRC-32 signatures; default is rotate-XOR).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_*                 script write port and shared script length
//   start                 launches all channels (ignored while busy)
//   inj_ready             per-channel accept from the router
//   gen_co/gen_do         flattened flits to router inputs
//   mon_ci/mon_di         flattened flits from router outputs
//   busy/done             run in progress / run complete (sticky)
//   rx_count/rx_sig       per-channel receive count and signature
module flit_traffic_gen
    import noc_pkg::*;
#(
    parameter int NCH   = 5,
    parameter int DEPTH = 16,
    parameter int DLY_W = 8,
    parameter int TMO   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NCH)-1:0]   cfg_ch,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [DLY_W-1:0]         cfg_dly,
    input  logic [CTRL_W-1:0]        cfg_ctrl,
    input  logic [DATA_W-1:0]        cfg_data,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     start,
    input  logic [NCH-1:0]           inj_ready,
    output logic [NCH*CTRL_W-1:0]    gen_co,
    output logic [NCH*DATA_W-1:0]    gen_do,
    input  logic [NCH*CTRL_W-1:0]    mon_ci,
    input  logic [NCH*DATA_W-1:0]    mon_di,
    output logic                     busy,
    output logic                     done,
    output logic [NCH*16-1:0]        rx_count,
    output logic [NCH*32-1:0]        rx_sig
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NCH);
    localparam int TW = $clog2(TMO + 1);

    logic          busy_q, busy_d, done_q, done_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW:0]   len_q, run_len;
    logic          start_acc, finish;
    logic [NCH-1:0] drained, mon_valid;

    assign start_acc = start && !busy_q;
    // Channels need the length on the start edge itself, before len_q is loaded.
    assign run_len   = start_acc ? cfg_len : len_q;

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        tmo_d  = tmo_q;
        finish = 1'b0;
        if (start_acc) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            tmo_d  = TW'(TMO);
        end else if (busy_q) begin
            // Timeout only runs once every channel is drained and the router is quiet.
            if (!(&drained) || (|mon_valid)) begin
                tmo_d = TW'(TMO);
            end else if (tmo_q == '0) begin
                finish = 1'b1;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tmo_q  <= '0;
            len_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            tmo_q  <= tmo_d;
            if (start_acc) begin
                len_q <= cfg_len;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign mon_valid[gi] = mon_ci[gi*CTRL_W + VALID_BIT];

            ftg_channel #(
                .DEPTH (DEPTH),
                .DLY_W (DLY_W)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (cfg_we && !busy_q && (cfg_ch == CW'(gi))),
                .wr_addr   (cfg_addr),
                .wr_dly    (cfg_dly),
                .wr_ctrl   (cfg_ctrl),
                .wr_data   (cfg_data),
                .run_len   (run_len),
                .run_start (start_acc),
                .run_stop  (finish),
                .inj_ready (inj_ready[gi]),
                .gen_co    (gen_co[gi*CTRL_W +: CTRL_W]),
                .gen_do    (gen_do[gi*DATA_W +: DATA_W]),
                .drained   (drained[gi]),
                .mon_en    (busy_q),
                .mon_valid (mon_valid[gi]),
                .mon_di    (mon_di[gi*DATA_W +: DATA_W]),
                .rx_count  (rx_count[gi*16 +: 16]),
                .rx_sig    (rx_sig[gi*32 +: 32])
            );
        end
    endgenerate

endmodule

// File: tb/tb_flit_traffic_gen.sv
// Directed bench for flit_traffic_gen with a one-cycle loopback "router".
module tb_flit_traffic_gen;
    import noc_pkg::*;

    localparam int NCH = 5;
    localparam int DEPTH = 16;
    localparam int DLY_W = 8;
    localparam int TMO = 20;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cfg_we = 1'b0;
    logic [2:0]              cfg_ch = '0;
    logic [3:0]              cfg_addr = '0;
    logic [DLY_W-1:0]        cfg_dly = '0;
    logic [CTRL_W-1:0]       cfg_ctrl = '0;
    logic [DATA_W-1:0]       cfg_data = '0;
    logic [4:0]              cfg_len = '0;
    logic                    start = 1'b0;
    logic [NCH-1:0]          inj_ready = '1;
    logic [NCH*CTRL_W-1:0]   gen_co;
    logic [NCH*DATA_W-1:0]   gen_do;
    logic [NCH*CTRL_W-1:0]   mon_ci = '0;
    logic [NCH*DATA_W-1:0]   mon_di = '0;
    logic                    busy, done;
    logic [NCH*16-1:0]       rx_count;
    logic [NCH*32-1:0]       rx_sig;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] sig_init, sig_gold;
    logic [NCH*CTRL_W-1:0] exp_co;
    logic [NCH*16-1:0] exp_rx;

    flit_traffic_gen #(.NCH(NCH), .DEPTH(DEPTH), .DLY_W(DLY_W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_dly(cfg_dly), .cfg_ctrl(cfg_ctrl), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .start(start), .inj_ready(inj_ready), .gen_co(gen_co), .gen_do(gen_do),
        .mon_ci(mon_ci), .mon_di(mon_di), .busy(busy), .done(done),
        .rx_count(rx_count), .rx_sig(rx_sig)
    );

    always #5 clk = ~clk;

    // Router stand-in: an accepted flit reappears on the same port one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (gen_co[i*CTRL_W + VALID_BIT] && inj_ready[i]) begin
                mon_ci[i*CTRL_W +: CTRL_W] <= gen_co[i*CTRL_W +: CTRL_W];
                mon_di[i*DATA_W +: DATA_W] <= gen_do[i*DATA_W +: DATA_W];
            end else begin
                mon_ci[i*CTRL_W +: CTRL_W] <= '0;
                mon_di[i*DATA_W +: DATA_W] <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s ok: %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] ctrl_of(input int ch);
        return gen_co[ch*CTRL_W +: CTRL_W];
    endfunction
    function automatic logic [15:0] rxc(input int ch);
        return rx_count[ch*16 +: 16];
    endfunction
    function automatic logic [31:0] rxs(input int ch);
        return rx_sig[ch*32 +: 32];
    endfunction

    function automatic logic [31:0] ref_crc(input logic [31:0] c0, input logic [31:0] w);
        logic [31:0] c;
        logic        fb;
        c = c0;
        for (int i = 0; i < 32; i++) begin
            fb = c[31] ^ w[31-i];
            c  = c << 1;
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int addr, input logic [DLY_W-1:0] dly,
                      input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_addr = 4'(addr);
        cfg_dly = dly; cfg_ctrl = c; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef SIG_CRC_EN
        sig_init = 32'hFFFF_FFFF;
        sig_gold = ref_crc(ref_crc(ref_crc(32'hFFFF_FFFF, 32'h1), 32'h8000_0000), 32'hF);
`else
        sig_init = 32'h0;
        sig_gold = 32'h0000_000A;
`endif
        step(); step(); step();
        check("rst_gen_co", gen_co, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx_count", rx_count, '0);
        check("rst_rx_sig", rx_sig, {NCH{sig_init}});
        rst = 1'b0;
        step();

        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < DEPTH; a++)
                wr(c, a, 8'd0, '0, '0);

        // 1: one flit each on ch0/ch1
        wr(0, 0, 8'd0, 22'h200001, 128'h0123456789abcdef0123456789abcdef);
        wr(1, 0, 8'd0, 22'h200802, 128'h0123456789abcdef0123456789abcdef);
        cfg_len = 5'd1;
        pulse_start();
        step();
        exp_co = '0;
        exp_co[0 +: CTRL_W] = 22'h200001;
        exp_co[CTRL_W +: CTRL_W] = 22'h200802;
        check("t1_flits", gen_co, exp_co);
        check("t1_data0", gen_do[0 +: DATA_W], 128'h0123456789abcdef0123456789abcdef);
        step();
        check("t1_zero", gen_co, '0);
        for (int k = 3; k <= 3 + TMO; k++) step();
        check("t1_done_early", done, 1'b0);
        step();
        check("t1_done", done, 1'b1);
        check("t1_busy", busy, 1'b0);
        exp_rx = '0;
        exp_rx[0 +: 16] = 16'd1;
        exp_rx[16 +: 16] = 16'd1;
        check("t1_rx", rx_count, exp_rx);

        // 2: delays 3,0,5 on ch2 -> exits at +4, +5, +11
        wr(0, 0, 8'd0, '0, '0);
        wr(1, 0, 8'd0, '0, '0);
        wr(2, 0, 8'd3, 22'h200201, 128'h1);
        wr(2, 1, 8'd0, 22'h200202, 128'h2);
        wr(2, 2, 8'd5, 22'h200203, 128'h3);
        cfg_len = 5'd3;
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t2_k%0d", k), ctrl_of(2),
                  (k == 4) ? 22'h200201 : (k == 5) ? 22'h200202 : (k == 11) ? 22'h200203 : 22'h0);
        end
        wait_done("t2_done");
        check("t2_rx", rxc(2), 16'd3);

        // 3: backpressure on ch4
        wr(2, 0, 8'd0, '0, '0);
        wr(2, 1, 8'd0, '0, '0);
        wr(4, 0, 8'd0, 22'h200401, 128'h41);
        wr(4, 1, 8'd0, 22'h200402, 128'h42);
        cfg_len = 5'd2;
        inj_ready[4] = 1'b0;
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("t3_hold%0d", k), ctrl_of(4), 22'h200401);
        end
        inj_ready[4] = 1'b1;
        step();
        check("t3_adv", ctrl_of(4), 22'h200402);
        step();
        check("t3_end", ctrl_of(4), 22'h0);
        wait_done("t3_done");
        check("t3_rx", rxc(4), 16'd2);

        // 4a: empty script
        cfg_len = 5'd0;
        pulse_start();
        step();
        check("t4_empty_co", gen_co, '0);
        check("t4_empty_busy", busy, 1'b1);
        for (int k = 2; k <= TMO; k++) step();
        check("t4_empty_early", done, 1'b0);
        step();
        check("t4_empty_done", done, 1'b1);
        check("t4_empty_rx", rx_count, '0);

        // 4b: full script on ch3, no wrap
        wr(4, 0, 8'd0, '0, '0);
        wr(4, 1, 8'd0, '0, '0);
        wr(2, 2, 8'd0, '0, '0);
        for (int a = 0; a < DEPTH; a++)
            wr(3, a, 8'd0, 22'h200300 + 22'(a), 128'(a));
        cfg_len = 5'd16;
        pulse_start();
        for (int k = 1; k <= 17; k++) begin
            step();
            check($sformatf("t4_full_k%0d", k), ctrl_of(3),
                  (k <= 16) ? 22'h200300 + 22'(k - 1) : 22'h0);
        end
        wait_done("t4_full_done");
        check("t4_full_rx", rxc(3), 16'd16);

        // 6: signature of three flits on ch1
        for (int a = 0; a < 3; a++) wr(3, a, 8'd0, '0, '0);
        wr(1, 0, 8'd0, 22'h200101, {32'h11111111, 32'h11111111, 32'h0, 32'h1});
        wr(1, 1, 8'd1, 22'h200102, {32'h80000000, 96'h0});
        wr(1, 2, 8'd2, 22'h200103, {32'h5, 32'h0, 32'h0, 32'hA});
        cfg_len = 5'd3;
        pulse_start();
        wait_done("t6_done");
        check("t6_sig", rxs(1), sig_gold);
        check("t6_rx", rxc(1), 16'd3);
        check("t6_sig_idle_ch", rxs(0), sig_init);

        // 5: reset mid-SEND, then rerun from the same memory
        pulse_start();
        step();
        check("t5_send", ctrl_of(1), 22'h200101);
        rst = 1'b1;
        step();
        check("t5_rst_co", gen_co, '0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rx", rx_count, '0);
        rst = 1'b0;
        pulse_start();
        wait_done("t5_rerun_done");
        check("t5_rerun_sig", rxs(1), sig_gold);

        // start and cfg_we while busy are ignored
        pulse_start();
        step();
        start = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_addr = 4'd2; cfg_dly = 8'd0;
        cfg_ctrl = 22'h2001FF; cfg_data = '0;
        step();
        start = 1'b0; cfg_we = 1'b0;
        step();
        check("t5_busy_k3", ctrl_of(1), 22'h200102);
        step(); step(); step();
        check("t5_busy_k6", ctrl_of(1), 22'h200103);
        wait_done("t5_busy_done");
        check("t5_busy_sig", rxs(1), sig_gold);
        check("t5_busy_rx", rxc(1), 16'd3);

        // start together with a write in IDLE: run uses the old entry
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_addr = 4'd0; cfg_dly = 8'd0;
        cfg_ctrl = 22'h2001EE; cfg_data = '0;
        start = 1'b1;
        step();
        start = 1'b0; cfg_we = 1'b0;
        step();
        check("t7_old_entry", ctrl_of(1), 22'h200101);
        wait_done("t7_done");
        pulse_start();
        step();
        check("t7_new_entry", ctrl_of(1), 22'h2001EE);
        wait_done("t7_done2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flit_traffic_gen.md
Name: flit_traffic_gen

Overview:
Synthesizable, parametrised stimulus and monitor engine for exercising a bufferless router (brouter) in place of hand-timed initial blocks.
- Each of NCH channels replays a scripted sequence of flits, each with an inter-flit delay, into a router input port.
- Each channel also counts and signs the flits returned on the matching router output port.
- Sits beside the router under test on FPGA or in simulation, with a config write port and a status readback.

Parameters:
NCH, 5, number of router ports driven and monitored
CTRL_W, 22, control word width; bit CTRL_W-1 is the flit valid bit
DATA_W, 128, flit data width
DEPTH, 16, script entries per channel (power of two, >=2)
DLY_W, 8, inter-flit delay field width
TMO, 64, idle cycles after last injection before done asserts

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  script write strobe
cfg_ch  in  $clog2(NCH)  channel written
cfg_addr  in  $clog2(DEPTH)  entry index
cfg_dly  in  DLY_W  idle cycles before this flit
cfg_ctrl  in  CTRL_W  control word of this flit
cfg_data  in  DATA_W  data word of this flit
cfg_len  in  $clog2(DEPTH)+1  entries used per channel (0..DEPTH), shared by all channels
start  in  1  one-cycle pulse that launches all channels
inj_ready  in  NCH  per-channel accept from router (tie 1 for ring ports)
gen_co  out  NCH*CTRL_W  flattened control to router inputs
gen_do  out  NCH*DATA_W  flattened data to router inputs
mon_ci  in  NCH*CTRL_W  router output control
mon_di  in  NCH*DATA_W  router output data
busy  out  1  any channel not IDLE/DONE, or timeout running
done  out  1  run complete; sticky until start or rst
rx_count  out  NCH*16  valid flits seen per channel, saturating
rx_sig  out  NCH*32  per-channel data signature

Behaviour:
- Reset: gen_co=0, gen_do=0, busy=0, done=0, rx_count=0, rx_sig=0, all channels IDLE. Script memory is not cleared.
- Per-channel FSM: IDLE -> (start) WAIT -> SEND -> WAIT or DRAIN.
  - WAIT: load dly of the current entry; decrement each cycle; move to SEND when the counter reaches 0. dly=0 means SEND on the next cycle.
  - SEND: drive the entry's ctrl/data.
    - inj_ready=1: advance the pointer. If pointer == cfg_len-1, go to DRAIN; else go to WAIT.
    - inj_ready=0: hold the flit unchanged.
  - DRAIN: drive zeros.
- cfg_len=0 on start: all channels go directly to DRAIN.
- Outside SEND, gen_co/gen_do are 0. Outputs are registered; first flit appears 1+dly0 cycles after start.
- Global timeout counter:
  - Starts when all channels are in DRAIN.
  - Any valid mon_ci (bit CTRL_W-1) reloads it to TMO.
  - When it reaches 0: done=1, busy=0, channels return to IDLE.
- Monitor, every cycle, per channel, when the valid bit is set:
  - rx_count += 1, saturating at 16'hFFFF.
  - rx_sig = {rx_sig[30:0], rx_sig[31]} ^ fold32(data), where fold32 XORs DATA_W/32 slices; DATA_W must be a multiple of 32.
  - The monitor counts during busy only; counters are cleared on start.
- start while busy: ignored.
- cfg_we while busy: ignored, so the script is stable during a run.
- rst mid-run: immediate return to reset state on the next edge; no partial flit is held.
- Simultaneous start and cfg_we in IDLE: the write lands in memory; the run uses memory as of the start edge, i.e. without that write.

Optional Feature:
SIG_CRC_EN
- Defined: rx_sig is CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflect), updated over fold32(data) per valid flit; cleared to 0xFFFFFFFF on start and reset.
- Undefined: the rotate-XOR signature above; reset/start value 0.

Decomposition:
- Shared package noc_pkg: CTRL_W, DATA_W, VALID_BIT, fold32 function, CRC32 polynomial constant.
- One sub-module: ftg_channel (script RAM, WAIT/SEND/DRAIN FSM, monitor counter and signature for one port), instantiated NCH times via generate. The top level holds the timeout, busy/done, and config decode.

Test Plan:
1. Two-flit replay.
   - Stimulus: ch0 script {dly0, ctrl 22'h200001, data 128'h0123456789abcdef0123456789abcdef}; ch1 {dly0, 22'h200802, same data}; cfg_len=1; start.
   - Required: both flits on gen_co one cycle after start, then zeros.
   - Required: done after the route plus TMO idle cycles; rx_count totals 2 across ports.
2. Delay timing.
   - Stimulus: ch2 entries dly=3,0,5.
   - Required: flits exit at start+4, start+5, start+11.
3. Backpressure.
   - Stimulus: ch4 inj_ready held 0 for 6 cycles during SEND.
   - Required: identical flit held 6 cycles, one advance on release; rx_count unchanged by holding.
4. Empty and full scripts.
   - Stimulus: cfg_len=0, then cfg_len=DEPTH=16.
   - Required: cfg_len=0 gives done after TMO with rx_count=0; cfg_len=16 sends 16 flits, pointer does not wrap.
5. Reset and ignored start.
   - Stimulus: rst asserted mid-SEND, then start without reload.
   - Required: gen_co=0 next cycle; the rerun reproduces the original rx_sig bit-exactly.
   - Stimulus: start while busy.
   - Required: no effect.
6. Signature check.
   - Stimulus: known 3-flit sequence on one port.
   - Required: rx_sig matches the golden value for the rotate-XOR signature, and for CRC-32 with SIG_CRC_EN defined.
